// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: control-stage generator for one fully-connected MLP
// layer. Walks every (output neuron j, input neuron i) pair in row-major
// order and drives registered addresses and strobes into the stage-1/stage-2
// pipeline register. Every output is a flop, so there is no combinational
// path from start to any output.
module mlp_layer_sequencer #(
  parameter int unsigned NUM_IN      = 784,
  parameter int unsigned NUM_OUT     = 16,
  parameter logic [11:0] IN_BASE     = 12'd0,
  parameter logic [11:0] OUT_BASE    = 12'd1024,
  parameter logic [15:0] WEIGHT_BASE = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done_1,
  output logic [11:0] neuron_addr_1,
  output logic [15:0] weight_addr_1,
  output logic        reset_mult_acc_1,
  output logic [11:0] out_neuron_addr_1,
  output logic        write_neuron_1
);

  localparam int unsigned IW = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1;
  localparam int unsigned JW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(NUM_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] naddr_q, naddr_d;
  logic [15:0] waddr_q, waddr_d;
  logic        rma_q, rma_d;
  logic [11:0] oaddr_q, oaddr_d;
  logic        wr_q, wr_d;

  // Compute the state and output values for the cycle after the next edge;
  // the counters always describe the pair currently shown on the outputs.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    naddr_d = naddr_q;
    waddr_d = waddr_q;
    rma_d   = 1'b0;
    oaddr_d = oaddr_q;
    wr_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_MAC;
          i_d     = '0;
          j_d     = '0;
          wcnt_d  = WEIGHT_BASE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          naddr_d = IN_BASE;
          waddr_d = WEIGHT_BASE;
          rma_d   = 1'b1;
        end
      end
      S_MAC: begin
        if (i_q == I_LAST) begin
          state_d = S_WRITE;
          wr_d    = 1'b1;
          oaddr_d = OUT_BASE + 12'(j_q);
        end else begin
          i_d     = i_q + IW'(1);
          wcnt_d  = wcnt_q + 16'd1;
          naddr_d = IN_BASE + 12'(i_q) + 12'd1;
          waddr_d = wcnt_q + 16'd1;
        end
      end
      S_WRITE: begin
        if (j_q == J_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_MAC;
          j_d     = j_q + JW'(1);
          i_d     = '0;
          wcnt_d  = wcnt_q + 16'd1;
          naddr_d = IN_BASE;
          waddr_d = wcnt_q + 16'd1;
          rma_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset abandons any layer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      wcnt_q  <= WEIGHT_BASE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      naddr_q <= '0;
      waddr_q <= '0;
      rma_q   <= 1'b0;
      oaddr_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      naddr_q <= naddr_d;
      waddr_q <= waddr_d;
      rma_q   <= rma_d;
      oaddr_q <= oaddr_d;
      wr_q    <= wr_d;
    end
  end

  assign busy              = busy_q;
  assign done_1            = done_q;
  assign neuron_addr_1     = naddr_q;
  assign weight_addr_1     = waddr_q;
  assign reset_mult_acc_1  = rma_q;
  assign out_neuron_addr_1 = oaddr_q;
  assign write_neuron_1    = wr_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Testbench for mlp_layer_sequencer: two instances (a 3x2 layer and a 1x3
// layer whose weight addresses wrap), checked cycle by cycle against an
// expected-output queue built from the row-major addressing formula.
module tb_mlp_layer_sequencer;

  localparam int          NI_A  = 3;
  localparam int          NO_A  = 2;
  localparam logic [11:0] INB   = 12'd0;
  localparam logic [11:0] OUTB  = 12'd1024;
  localparam logic [15:0] WB_A  = 16'd100;
  localparam int          NI_B  = 1;
  localparam int          NO_B  = 3;
  localparam logic [15:0] WB_B  = 16'd65534;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [11:0] naddr;
    logic [15:0] waddr;
    logic        rma;
    logic [11:0] oaddr;
    logic        write;
  } obs_t;

  logic clk;
  logic resetA, startA, resetB, startB;
  logic busyA, doneA, rmaA, wrA;
  logic [11:0] naddrA, oaddrA;
  logic [15:0] waddrA;
  logic busyB, doneB, rmaB, wrB;
  logic [11:0] naddrB, oaddrB;
  logic [15:0] waddrB;

  obs_t expQ[$];
  obs_t expV, obsV;
  logic [11:0] lastOutA, lastOutB;
  int nChecks = 0;
  int nFail = 0;

  mlp_layer_sequencer #(
    .NUM_IN(NI_A), .NUM_OUT(NO_A), .IN_BASE(INB), .OUT_BASE(OUTB), .WEIGHT_BASE(WB_A)
  ) dutA (
    .clk(clk), .reset(resetA), .start(startA), .busy(busyA), .done_1(doneA),
    .neuron_addr_1(naddrA), .weight_addr_1(waddrA), .reset_mult_acc_1(rmaA),
    .out_neuron_addr_1(oaddrA), .write_neuron_1(wrA)
  );

  mlp_layer_sequencer #(
    .NUM_IN(NI_B), .NUM_OUT(NO_B), .IN_BASE(INB), .OUT_BASE(OUTB), .WEIGHT_BASE(WB_B)
  ) dutB (
    .clk(clk), .reset(resetB), .start(startB), .busy(busyB), .done_1(doneB),
    .neuron_addr_1(naddrB), .weight_addr_1(waddrB), .reset_mult_acc_1(rmaB),
    .out_neuron_addr_1(oaddrB), .write_neuron_1(wrB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t sampleA();
    obs_t o;
    o = '{busy: busyA, done: doneA, naddr: naddrA, waddr: waddrA, rma: rmaA, oaddr: oaddrA, write: wrA};
    return o;
  endfunction

  function automatic obs_t sampleB();
    obs_t o;
    o = '{busy: busyB, done: doneB, naddr: naddrB, waddr: waddrB, rma: rmaB, oaddr: oaddrB, write: wrB};
    return o;
  endfunction

  // Expected MAC/WRITE cycles of one layer, weights addressed row-major.
  task automatic pushLayer(input int ni, input int no, input logic [15:0] wBase,
                           inout logic [11:0] lastOut);
    obs_t e;
    for (int j = 0; j < no; j++) begin
      for (int i = 0; i < ni; i++) begin
        e.busy  = 1'b1;
        e.done  = 1'b0;
        e.naddr = INB + 12'(i);
        e.waddr = wBase + 16'(j * ni + i);
        e.rma   = (i == 0);
        e.oaddr = lastOut;
        e.write = 1'b0;
        expQ.push_back(e);
      end
      e.rma   = 1'b0;
      e.write = 1'b1;
      e.oaddr = OUTB + 12'(j);
      lastOut = e.oaddr;
      expQ.push_back(e);
    end
  endtask

  task automatic pushDone(input int count, input int ni, input int no,
                          input logic [15:0] wBase, input logic [11:0] lastOut);
    obs_t e;
    e.busy  = 1'b0;
    e.done  = 1'b1;
    e.naddr = INB + 12'(ni - 1);
    e.waddr = wBase + 16'(no * ni - 1);
    e.rma   = 1'b0;
    e.oaddr = lastOut;
    e.write = 1'b0;
    for (int k = 0; k < count; k++) expQ.push_back(e);
  endtask

  task automatic pushIdle(input int count);
    for (int k = 0; k < count; k++) expQ.push_back('0);
  endtask

  task automatic test_reset();
    resetA = 1'b1; resetB = 1'b1; startA = 1'b1; startB = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (sampleA() !== obs_t'('0)) begin
      nFail++;
      $display("[TB] FAIL reset_A: got %h, expected 0", sampleA());
    end
    nChecks++;
    if (sampleB() !== obs_t'('0)) begin
      nFail++;
      $display("[TB] FAIL reset_B: got %h, expected 0", sampleB());
    end
    resetA = 1'b0; resetB = 1'b0; startA = 1'b0; startB = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      nChecks++;
      if (sampleA() !== obs_t'('0) || sampleB() !== obs_t'('0)) begin
        nFail++;
        $display("[TB] FAIL idle_after_reset cycle %0d: got A=%h B=%h, expected 0", k, sampleA(), sampleB());
      end
    end
    lastOutA = '0;
    lastOutB = '0;
  endtask

  task automatic test_basic_layer();
    pushLayer(NI_A, NO_A, WB_A, lastOutA);
    pushDone(3, NI_A, NO_A, WB_A, lastOutA);
    startA = 1'b1;
    for (int k = 0; expQ.size() > 0; k++) begin
      @(posedge clk); #1;
      startA = 1'b0;
      expV = expQ.pop_front();
      obsV = sampleA();
      nChecks++;
      if (obsV !== expV) begin
        nFail++;
        $display("[TB] FAIL basic_layer cycle %0d: got busy=%b done=%b n=%0d w=%0d rma=%b out=%0d wr=%b, expected busy=%b done=%b n=%0d w=%0d rma=%b out=%0d wr=%b",
                 k, obsV.busy, obsV.done, obsV.naddr, obsV.waddr, obsV.rma, obsV.oaddr, obsV.write,
                 expV.busy, expV.done, expV.naddr, expV.waddr, expV.rma, expV.oaddr, expV.write);
      end
    end
  endtask

  task automatic test_ignored_start();
    pushLayer(NI_A, NO_A, WB_A, lastOutA);
    pushDone(3, NI_A, NO_A, WB_A, lastOutA);
    startA = 1'b1;
    for (int k = 0; expQ.size() > 0; k++) begin
      @(posedge clk); #1;
      startA = (k == 0 || k == 2);
      expV = expQ.pop_front();
      obsV = sampleA();
      nChecks++;
      if (obsV !== expV) begin
        nFail++;
        $display("[TB] FAIL ignored_start cycle %0d: got %h, expected %h", k, obsV, expV);
      end
    end
    startA = 1'b0;
  endtask

  task automatic test_back_to_back();
    pushLayer(NI_A, NO_A, WB_A, lastOutA);
    pushDone(1, NI_A, NO_A, WB_A, lastOutA);
    pushLayer(NI_A, NO_A, WB_A, lastOutA);
    pushDone(3, NI_A, NO_A, WB_A, lastOutA);
    startA = 1'b1;
    for (int k = 0; expQ.size() > 0; k++) begin
      @(posedge clk); #1;
      startA = (k < 9);
      expV = expQ.pop_front();
      obsV = sampleA();
      nChecks++;
      if (obsV !== expV) begin
        nFail++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h, expected %h", k, obsV, expV);
      end
    end
    startA = 1'b0;
  endtask

  task automatic test_mid_reset();
    pushLayer(NI_A, NO_A, WB_A, lastOutA);
    while (expQ.size() > 5) void'(expQ.pop_back());
    pushIdle(3);
    startA = 1'b1;
    for (int k = 0; expQ.size() > 0; k++) begin
      @(posedge clk); #1;
      startA = 1'b0;
      resetA = (k == 4);
      expV = expQ.pop_front();
      obsV = sampleA();
      nChecks++;
      if (obsV !== expV) begin
        nFail++;
        $display("[TB] FAIL mid_reset cycle %0d: got %h, expected %h", k, obsV, expV);
      end
    end
    lastOutA = '0;
    pushLayer(NI_A, NO_A, WB_A, lastOutA);
    pushDone(2, NI_A, NO_A, WB_A, lastOutA);
    startA = 1'b1;
    for (int k = 0; expQ.size() > 0; k++) begin
      @(posedge clk); #1;
      startA = 1'b0;
      expV = expQ.pop_front();
      obsV = sampleA();
      nChecks++;
      if (obsV !== expV) begin
        nFail++;
        $display("[TB] FAIL rerun_after_reset cycle %0d: got %h, expected %h", k, obsV, expV);
      end
    end
  endtask

  task automatic test_reset_with_start();
    resetA = 1'b1;
    startA = 1'b1;
    pushIdle(3);
    for (int k = 0; expQ.size() > 0; k++) begin
      @(posedge clk); #1;
      resetA = 1'b0;
      startA = 1'b0;
      expV = expQ.pop_front();
      obsV = sampleA();
      nChecks++;
      if (obsV !== expV) begin
        nFail++;
        $display("[TB] FAIL reset_with_start cycle %0d: got %h, expected %h", k, obsV, expV);
      end
    end
    lastOutA = '0;
  endtask

  task automatic test_wrap();
    int busyCount;
    busyCount = 0;
    pushLayer(NI_B, NO_B, WB_B, lastOutB);
    pushDone(2, NI_B, NO_B, WB_B, lastOutB);
    startB = 1'b1;
    for (int k = 0; expQ.size() > 0; k++) begin
      @(posedge clk); #1;
      startB = 1'b0;
      expV = expQ.pop_front();
      obsV = sampleB();
      if (obsV.busy === 1'b1) busyCount++;
      nChecks++;
      if (obsV !== expV) begin
        nFail++;
        $display("[TB] FAIL wrap cycle %0d: got busy=%b done=%b n=%0d w=%0d rma=%b out=%0d wr=%b, expected busy=%b done=%b n=%0d w=%0d rma=%b out=%0d wr=%b",
                 k, obsV.busy, obsV.done, obsV.naddr, obsV.waddr, obsV.rma, obsV.oaddr, obsV.write,
                 expV.busy, expV.done, expV.naddr, expV.waddr, expV.rma, expV.oaddr, expV.write);
      end
    end
    nChecks++;
    if (busyCount != 6) begin
      nFail++;
      $display("[TB] FAIL wrap_busy_count: got %0d, expected 6", busyCount);
    end
  endtask

  initial begin
    resetA = 1'b1; resetB = 1'b1; startA = 1'b0; startB = 1'b0;
    lastOutA = '0; lastOutB = '0;
    #1;
    test_reset();
    test_basic_layer();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_reset_with_start();
    test_basic_layer();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
